// File: rtl/conv_32_8_if.sv
// Handshake bundle for the 32-to-8 serializer: a word stream going in and a byte stream coming out.
// master is the environment side; slave is the serializer itself.
interface conv_32_8_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        in_ready;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        out_ready;

  modport master (
    output data_in, valid_in, out_ready,
    input  in_ready, data_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, out_ready,
    output in_ready, data_out, valid_out
  );
endinterface

// File: rtl/conv_32_8.sv
// Word-to-byte serializer: accepts 32-bit words and emits them as four bytes, one per clk (clk_4f).
// A new word can be loaded on the same edge that the last byte of the previous word is taken.
module conv_32_8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  conv_32_8_if.slave  bus
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [31:0] shreg, shreg_n;
  logic [7:0]  dout_n;
  logic        vout_n;
  logic        accept;

  // The byte currently on data_out always lives at the leading end of the shift register.
  function automatic logic [7:0] lead_byte(input logic [31:0] w);
    return MSB_FIRST ? w[31:24] : w[7:0];
  endfunction

  function automatic logic [31:0] shift_word(input logic [31:0] w);
    return MSB_FIRST ? {w[23:0], 8'h00} : {8'h00, w[31:8]};
  endfunction

  // Ready only when nothing is held, or when the last byte is leaving on this very edge.
  assign bus.in_ready = (state == IDLE) ||
                        ((state == SEND) && (cnt == 2'd3) && bus.out_ready);
  assign accept       = bus.valid_in && bus.in_ready;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    dout_n  = bus.data_out;
    vout_n  = bus.valid_out;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SEND;
          cnt_n   = 2'd0;
          shreg_n = bus.data_in;
          dout_n  = lead_byte(bus.data_in);
          vout_n  = 1'b1;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (cnt != 2'd3) begin
            cnt_n   = cnt + 2'd1;
            shreg_n = shift_word(shreg);
            dout_n  = lead_byte(shift_word(shreg));
          end else if (accept) begin
            state_n = SEND;
            cnt_n   = 2'd0;
            shreg_n = bus.data_in;
            dout_n  = lead_byte(bus.data_in);
            vout_n  = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = 2'd0;
            shreg_n = 32'h0;
            dout_n  = 8'h00;
            vout_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 2'd0;
        shreg_n = 32'h0;
        dout_n  = 8'h00;
        vout_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      shreg         <= 32'h0;
      bus.data_out  <= 8'h00;
      bus.valid_out <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      shreg         <= shreg_n;
      bus.data_out  <= dout_n;
      bus.valid_out <= vout_n;
    end
  end

endmodule
